// File: rtl/apb_sram_param.sv
// APB4 slave SRAM: parametrised width/depth/wait states, byte strobes,
// pslverr on out-of-range words, abort on dropped select.
// Ports: pclk/preset (async, active low) clock and reset.
//        psel/penable/pwrite/paddr/pwdata/pstrb APB request inputs.
//        prdata/pready/pslverr APB response outputs.
module apb_sram_param #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IW    = ADDR_W - OFF_W;
    localparam int MW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [IW:0] DEPTH_C = (IW + 1)'(DEPTH);
    localparam logic [3:0]  WS_C    = 4'(WAIT_STATES);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [MW-1:0]       word_q, word_d;
    logic                write_q, write_d;
    logic                inr_q, inr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]       strb_q, strb_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [IW-1:0]       idx_in;
    logic                inr_in;
    logic                setup;
    logic                xfer;
    logic                last;
    logic                load;
    logic                we;
    logic [MW-1:0]       rd_idx;
    logic                unused_paddr;

    // Byte-offset bits are deliberately ignored.
    assign unused_paddr = ^paddr;

    assign idx_in = paddr[ADDR_W-1:OFF_W];
    assign inr_in = ({1'b0, idx_in} < DEPTH_C);
    assign setup  = psel & ~penable;
    assign xfer   = psel & penable;

    // Response decoded from registered state only.
    assign last    = (state_q == S_ACCESS) && (cnt_q == WS_C);
    assign pready  = last;
    assign pslverr = last & ~inr_q;
    assign prdata  = prdata_q;

    // Commit only on a completed, in-range write.
    assign we = last & xfer & write_q & inr_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        write_d  = write_q;
        inr_d    = inr_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        prdata_d = '0;
        load     = 1'b0;
        rd_idx   = word_q;
        unique case (state_q)
            S_IDLE: begin
                rd_idx = idx_in[MW-1:0];
                if (setup) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                    word_d  = idx_in[MW-1:0];
                    write_d = pwrite;
                    inr_d   = inr_in;
                    wdata_d = pwdata;
                    strb_d  = pstrb;
                    // No wait states: data must be ready next cycle.
                    load    = ~pwrite & inr_in & (WS_C == 4'd0);
                end
            end
            S_ACCESS: begin
                if (xfer) begin
                    if (cnt_q == WS_C) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        // Load on the edge entering the pready cycle.
                        load  = ~write_q & inr_q
                              & ((cnt_q + 4'd1) == WS_C);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
        if (load) begin
            prdata_d = mem[rd_idx];
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            word_q   <= '0;
            write_q  <= 1'b0;
            inr_q    <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            write_q  <= write_d;
            inr_q    <= inr_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            prdata_q <= prdata_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (strb_q[i]) begin
                    mem[word_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_sram_param.sv
// Testbench for apb_sram_param: three instances with 0, 2 and 3 wait states,
// table-driven transfers plus abort and reset sequences, scoreboard checked.
module tb_apb_sram_param;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int WS_OF [3] = '{0, 2, 3};

    logic            pclk = 1'b0;
    logic            preset = 1'b0;
    logic [2:0]      psel = '0;
    logic            penable = 1'b0;
    logic            pwrite = 1'b0;
    logic [AW-1:0]   paddr = '0;
    logic [DW-1:0]   pwdata = '0;
    logic [DW/8-1:0] pstrb = '0;
    logic [DW-1:0]   prdata [3];
    logic            pready [3];
    logic            pslverr [3];

    int tests = 0;
    int fails = 0;

    always #5 pclk = ~pclk;

    apb_sram_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4096),
                     .WAIT_STATES(0)) u_ws0 (
        .pclk(pclk), .preset(preset), .psel(psel[0]),
        .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[0]),
        .pready(pready[0]), .pslverr(pslverr[0]));

    apb_sram_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4096),
                     .WAIT_STATES(2)) u_ws2 (
        .pclk(pclk), .preset(preset), .psel(psel[1]),
        .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[1]),
        .pready(pready[1]), .pslverr(pslverr[1]));

    apb_sram_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4096),
                     .WAIT_STATES(3)) u_ws3 (
        .pclk(pclk), .preset(preset), .psel(psel[2]),
        .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[2]),
        .pready(pready[2]), .pslverr(pslverr[2]));

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[16];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bus_idle();
        @(negedge pclk);
        psel    = '0;
        penable = 1'b0;
    endtask

    // One full transfer on instance i; expectation queued at drive time.
    task automatic xfer(int i, logic wr, logic [15:0] a, logic [31:0] d,
                        logic [3:0] s, logic [31:0] erd, logic eerr);
        exp_t e;
        int   n;
        bit   seen;
        bit   zok;
        e.wr    = wr;
        e.rdata = erd;
        e.err   = eerr;
        e.lat   = WS_OF[i] + 1;
        sb.push_back(e);
        @(negedge pclk);
        psel    = '0;
        psel[i] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        pstrb   = s;
        @(negedge pclk);
        penable = 1'b1;
        // Bus changes during access must be ignored.
        paddr   = a ^ 16'h0004;
        pwdata  = ~d;
        seen = 1'b0;
        zok  = 1'b1;
        n    = 0;
        for (int k = 1; k <= 40; k++) begin
            if (pready[i] === 1'b1) begin
                n    = k;
                seen = 1'b1;
                break;
            end
            if (prdata[i] !== '0 || pslverr[i] !== 1'b0) zok = 1'b0;
            @(negedge pclk);
        end
        e = sb.pop_front();
        chk("pready_seen", 64'(seen), 64'd1);
        chk("wait_outputs_zero", 64'(zok), 64'd1);
        if (seen) begin
            chk("latency", 64'(n), 64'(e.lat));
            chk("pslverr", 64'(pslverr[i]), 64'(e.err));
            if (!e.wr) chk("prdata", 64'(prdata[i]), 64'(e.rdata));
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 16'h0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 16'h0010, 32'h11223344, 4'h5, 32'h0, 1'b0};
        tbl[3]  = '{1'b0, 16'h0010, 32'h0, 4'h0, 32'hDE22BE44, 1'b0};
        tbl[4]  = '{1'b1, 16'h0000, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0};
        tbl[5]  = '{1'b1, 16'h4000, 32'h00000001, 4'hF, 32'h0, 1'b1};
        tbl[6]  = '{1'b0, 16'h0000, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0};
        tbl[7]  = '{1'b0, 16'h4000, 32'h0, 4'h0, 32'h0, 1'b1};
        tbl[8]  = '{1'b0, 16'h0013, 32'h0, 4'h0, 32'hDE22BE44, 1'b0};
        tbl[9]  = '{1'b1, 16'h0010, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0};
        tbl[10] = '{1'b0, 16'h0010, 32'h0, 4'h0, 32'hDE22BE44, 1'b0};
        tbl[11] = '{1'b1, 16'hFFFC, 32'h12345678, 4'hF, 32'h0, 1'b1};
        tbl[12] = '{1'b1, 16'h3FFC, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0};
        tbl[13] = '{1'b0, 16'h3FFC, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0};
        tbl[14] = '{1'b1, 16'h0010, 32'h99887766, 4'hA, 32'h0, 1'b0};
        tbl[15] = '{1'b0, 16'h0010, 32'h0, 4'h0, 32'h99227744, 1'b0};

        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_outputs",
                {31'd0, pready[i], pslverr[i], prdata[i]}, 64'd0);
        end
        repeat (2) @(negedge pclk);
        preset = 1'b1;

        // Zero wait states, back-to-back table.
        for (int v = 0; v < 16; v++) begin
            xfer(0, tbl[v].wr, tbl[v].addr, tbl[v].wdata,
                 tbl[v].strb, tbl[v].erd, tbl[v].eerr);
        end
        bus_idle();

        // Three wait states: 5 cycles from setup to completion.
        xfer(2, 1'b1, 16'h0100, 32'h0F0F0F0F, 4'hF, 32'h0, 1'b0);
        xfer(2, 1'b0, 16'h0100, 32'h0, 4'h0, 32'h0F0F0F0F, 1'b0);
        xfer(2, 1'b0, 16'h8000, 32'h0, 4'h0, 32'h0, 1'b1);
        bus_idle();

        // Abort in second access cycle, two wait states.
        xfer(1, 1'b1, 16'h0020, 32'h12345678, 4'hF, 32'h0, 1'b0);
        bus_idle();
        @(negedge pclk);
        psel[1] = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 16'h0020;
        pwdata  = 32'hAAAA5555;
        pstrb   = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        chk("abort_acc1_pready", 64'(pready[1]), 64'd0);
        @(negedge pclk);
        psel    = '0;
        penable = 1'b0;
        chk("abort_acc2_pready", 64'(pready[1]), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            chk("abort_idle_pready", 64'(pready[1]), 64'd0);
        end
        xfer(1, 1'b0, 16'h0020, 32'h0, 4'h0, 32'h12345678, 1'b0);
        bus_idle();

        // Reset asserted in the pready cycle of a write.
        xfer(1, 1'b1, 16'h0030, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
        bus_idle();
        @(negedge pclk);
        psel[1] = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 16'h0030;
        pwdata  = 32'hFFFFFFFF;
        pstrb   = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        repeat (2) @(negedge pclk);
        chk("rst_wr_pready_before", 64'(pready[1]), 64'd1);
        preset = 1'b0;
        #1;
        chk("rst_wr_outputs",
            {31'd0, pready[1], pslverr[1], prdata[1]}, 64'd0);
        @(negedge pclk);
        psel    = '0;
        penable = 1'b0;
        @(negedge pclk);
        preset = 1'b1;
        xfer(1, 1'b0, 16'h0030, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);
        bus_idle();

        // Reset asserted while read data is on the bus.
        @(negedge pclk);
        psel[1] = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 16'h0030;
        @(negedge pclk);
        penable = 1'b1;
        repeat (2) @(negedge pclk);
        chk("rst_rd_prdata_before", 64'(prdata[1]), 64'h0BADF00D);
        preset = 1'b0;
        #1;
        chk("rst_rd_outputs",
            {31'd0, pready[1], pslverr[1], prdata[1]}, 64'd0);
        @(negedge pclk);
        psel    = '0;
        penable = 1'b0;
        @(negedge pclk);
        preset = 1'b1;
        xfer(1, 1'b0, 16'h0020, 32'h0, 4'h0, 32'h12345678, 1'b0);
        bus_idle();

        repeat (2) @(negedge pclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
